ahb_slave_arbiter: RTL



---
 rtl/ahb_ic_pkg.sv | 16 +
 rtl/rr_pick.sv | 41 ++++
 rtl/ahb_slave_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ahb_ic_pkg.sv
// rtl/ahb_ic_pkg.sv - shared types and constants for the ahb_ic interconnect slave ports.
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int DEF_NUM_MASTERS    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester above last, else lowest.
module rr_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int W = $clog2(N);

  logic [N-1:0] masked;
  logic         found;

  always_comb begin
    masked  = '0;
    idx_o   = '0;
    found   = 1'b0;
    any_o   = |req_i;
    for (int i = 0; i < N; i++) begin
      masked[i] = req_i[i] && (i > int'(last_i));
    end
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx_o = W'(i);
      end
    end
    // Nothing above the pointer: wrap around to the lowest requester.
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        idx_o = W'(i);
      end
    end
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - round-robin arbiter and address/data phase sequencer
// for one shared AHB slave port, with data-phase timeout.
module ahb_slave_arbiter
  import ahb_ic_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int MW            = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hreq_m,
  input  logic                   hready_s,
  input  logic                   hresp_s,
  output logic [NUM_MASTERS-1:0] hgrant_m,
  output logic                   hsel_s,
  output logic [MW-1:0]          sel_addr,
  output logic [MW-1:0]          sel_data,
  output logic [NUM_MASTERS-1:0] hready_m,
  output logic [NUM_MASTERS-1:0] hresp_m,
  output logic                   timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [MW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   hsel_q, hsel_d;
  logic [MW-1:0]          sel_addr_q, sel_addr_d;
  logic [MW-1:0]          sel_data_q, sel_data_d;
  logic [NUM_MASTERS-1:0] hready_q, hready_d;
  logic [NUM_MASTERS-1:0] hresp_q, hresp_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] data_onehot;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [MW-1:0]          pick_idx;
  logic                   pick_any;
  logic                   arb;

  assign data_onehot = NUM_MASTERS'(1) << sel_data_q;
  // The completing master sits out the decision made on its own completion.
  assign pick_req = (state_q == ST_DATA) ? (hreq_m & ~data_onehot) : hreq_m;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i   (pick_req),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = '0;
    hsel_d     = 1'b0;
    sel_addr_d = sel_addr_q;
    sel_data_d = sel_data_q;
    hready_d   = '0;
    hresp_d    = '0;
    timeout_d  = 1'b0;
    arb        = 1'b0;
    case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_ADDR: begin
        sel_data_d = sel_addr_q;
        cnt_d      = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (hready_s) begin
          hready_d = data_onehot;
          hresp_d  = hresp_s ? data_onehot : '0;
          arb      = 1'b1;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          hready_d  = data_onehot;
          hresp_d   = data_onehot;
          timeout_d = 1'b1;
          arb       = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (arb) begin
      if (pick_any) begin
        grant_d    = pick_grant;
        hsel_d     = 1'b1;
        sel_addr_d = pick_idx;
        last_d     = pick_idx;
        state_d    = ST_ADDR;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      last_q     <= MW'(NUM_MASTERS - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      hsel_q     <= 1'b0;
      sel_addr_q <= '0;
      sel_data_q <= '0;
      hready_q   <= '0;
      hresp_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      hsel_q     <= hsel_d;
      sel_addr_q <= sel_addr_d;
      sel_data_q <= sel_data_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hgrant_m = grant_q;
  assign hsel_s   = hsel_q;
  assign sel_addr = sel_addr_q;
  assign sel_data = sel_data_q;
  assign hready_m = hready_q;
  assign hresp_m  = hresp_q;
  assign timeout  = timeout_q;

endmodule
